// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a shift register's d/en/dir for exactly `count` enabled clocks.
// Optional feature macro SHIFT_SEQ_CAPTURE_EN adds sr_out capture into result at completion.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_abort,
`ifdef SHIFT_SEQ_CAPTURE_EN
    input  logic [WIDTH-1:0] sr_out,
    output logic [WIDTH-1:0] result,
`endif
    output logic [WIDTH-1:0] sr_d,
    output logic             sr_en,
    output logic [1:0]       sr_dir,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic             abort_q;
    logic             abort_d;
    logic             accept;

    // cmd_ready is itself a register, so it is low on the first edge after reset release.
    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        abort_d     = abort_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    abort_d = 1'b0;
                    if (cmd_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = SHIFT;
                        remaining_d = cmd_count;
                    end
                end
            end
            SHIFT: begin
                // The last enable always completes normally, even with abort high.
                if (remaining_q <= CNT_ONE) begin
                    state_d = DONE;
                end else if (cmd_abort) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                end else begin
                    remaining_d = remaining_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            abort_q     <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            sr_en       <= 1'b0;
            sr_d        <= '0;
            sr_dir      <= 2'b00;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            abort_q     <= abort_d;
            cmd_ready   <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
            sr_en       <= (state_d == SHIFT);
            done        <= (state_q == DONE);
            aborted     <= (state_q == DONE) && abort_q;
            if (accept) begin
                sr_d   <= cmd_data;
                sr_dir <= cmd_dir;
            end
        end
    end

`ifdef SHIFT_SEQ_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            result <= '0;
        end else if (state_q == DONE) begin
            result <= sr_out;
        end
    end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: cycle-index model plus directed literal checks.
// Define SHIFT_SEQ_CAPTURE_EN to also exercise the sr_out/result capture path.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    logic [3:0] cmd_count;
    logic [7:0] cmd_data;
    logic       cmd_abort;
    logic [7:0] sr_d;
    logic       sr_en;
    logic [1:0] sr_dir;
    logic       busy;
    logic       done;
    logic       aborted;
`ifdef SHIFT_SEQ_CAPTURE_EN
    logic [7:0] result;
`endif
    logic [7:0] sr_q;

    int vec_count  = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Model state: the active command described by its accept edge and enable length.
    logic       have_cmd = 1'b0;
    int         m_start  = 0;
    int         m_n      = 0;
    int         m_fin    = 0;
    logic       m_ab     = 1'b0;
    logic       exp_ready   = 1'b0;
    logic       exp_busy    = 1'b0;
    logic       exp_en      = 1'b0;
    logic       exp_done    = 1'b0;
    logic       exp_aborted = 1'b0;
    logic [7:0] exp_d       = 8'h00;
    logic [1:0] exp_dir     = 2'b00;
    logic [7:0] exp_result  = 8'h00;

    shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir  (cmd_dir),
        .cmd_count(cmd_count),
        .cmd_data (cmd_data),
        .cmd_abort(cmd_abort),
`ifdef SHIFT_SEQ_CAPTURE_EN
        .sr_out   (sr_q),
        .result   (result),
`endif
        .sr_d     (sr_d),
        .sr_en    (sr_en),
        .sr_dir   (sr_dir),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift register: 00 hold, 01 left, 10 right, 11 load d.
    always @(posedge clk) begin
        if (!rstn) begin
            sr_q <= 8'h00;
        end else if (sr_en) begin
            case (sr_dir)
                2'b01:   sr_q <= {sr_q[6:0], 1'b0};
                2'b10:   sr_q <= {1'b0, sr_q[7:1]};
                2'b11:   sr_q <= sr_d;
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: outputs of cycle e+1 derived from its offset j to the accept edge.
    always @(posedge clk) begin
        int k;
        int j;
        logic ready_now;
        cyc++;
        if (!rstn) begin
            have_cmd    = 1'b0;
            exp_ready   = 1'b0;
            exp_busy    = 1'b0;
            exp_en      = 1'b0;
            exp_done    = 1'b0;
            exp_aborted = 1'b0;
            exp_d       = 8'h00;
            exp_dir     = 2'b00;
            exp_result  = 8'h00;
        end else begin
            ready_now = exp_ready;
            if (have_cmd) begin
                k = cyc - m_start;
                if (cmd_abort && k >= 1 && k <= m_fin && k < m_n) begin
                    m_fin = k;
                    m_ab  = 1'b1;
                end
                if (k == m_fin + 1) exp_result = sr_q;
            end
            if (ready_now && cmd_valid) begin
                have_cmd = 1'b1;
                m_start  = cyc;
                m_n      = int'(cmd_count);
                m_fin    = int'(cmd_count);
                m_ab     = 1'b0;
                exp_d    = cmd_data;
                exp_dir  = cmd_dir;
            end
            j           = cyc + 1 - m_start;
            exp_en      = have_cmd && j >= 1 && j <= m_fin;
            exp_busy    = have_cmd && j >= 1 && j <= m_fin + 1;
            exp_done    = have_cmd && j == m_fin + 2;
            exp_aborted = exp_done && m_ab;
            exp_ready   = !exp_busy;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("cmd_ready", cmd_ready, exp_ready);
            checkOutput("busy", busy, exp_busy);
            checkOutput("sr_en", sr_en, exp_en);
            checkOutput("done", done, exp_done);
            checkOutput("aborted", aborted, exp_aborted);
            checkOutput("sr_d", sr_d, exp_d);
            checkOutput("sr_dir", sr_dir, exp_dir);
`ifdef SHIFT_SEQ_CAPTURE_EN
            checkOutput("result", result, exp_result);
`endif
        end
    end

    // Called at a negedge with the sequencer idle; returns at the negedge after done.
    task automatic applyStimulus(input logic [1:0] dir, input logic [3:0] count, input logic [7:0] data,
                                 input int abort_at, input logic [31:0] en_mask, input int done_at,
                                 input logic exp_ab);
        checkOutput("lit_ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = count;
        cmd_data  = data;
        @(posedge clk);
        for (int c = 1; c <= done_at + 1; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_abort = (c == abort_at);
            checkOutput("lit_en", sr_en, en_mask[c]);
            checkOutput("lit_busy", busy, c < done_at);
            checkOutput("lit_done", done, c == done_at);
            checkOutput("lit_aborted", aborted, (c == done_at) && exp_ab);
            if (en_mask[c]) begin
                checkOutput("lit_sr_d", sr_d, data);
                checkOutput("lit_sr_dir", sr_dir, dir);
            end
        end
        cmd_abort = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 2'b00;
        cmd_count = 4'd0;
        cmd_data  = 8'h00;
        cmd_abort = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("lit_rst_ready", cmd_ready, 1'b0);
            checkOutput("lit_rst_en", sr_en, 1'b0);
            checkOutput("lit_rst_busy", busy, 1'b0);
            checkOutput("lit_rst_done", done, 1'b0);
            checkOutput("lit_rst_sr_d", sr_d, 8'h00);
        end
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("lit_release_ready", cmd_ready, 1'b1);
        checkOutput("lit_release_en", sr_en, 1'b0);

        applyStimulus(2'b01, 4'd4, 8'h01, 0, 32'h0000_001E, 6, 1'b0);
        applyStimulus(2'b10, 4'd0, 8'hA5, 1, 32'h0000_0000, 2, 1'b0);
        applyStimulus(2'b01, 4'd7, 8'h5A, 3, 32'h0000_000E, 5, 1'b1);
        applyStimulus(2'b10, 4'd7, 8'h81, 7, 32'h0000_00FE, 9, 1'b0);
        applyStimulus(2'b01, 4'd15, 8'h33, 0, 32'h0000_FFFE, 17, 1'b0);

        // Back-to-back: second command held valid is taken only in the done cycle.
        cmd_valid = 1'b1;
        cmd_dir   = 2'b01;
        cmd_count = 4'd3;
        cmd_data  = 8'h3C;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_dir   = 2'b11;
                cmd_count = 4'd2;
                cmd_data  = 8'hC3;
            end
            if (c == 6) cmd_valid = 1'b0;
            checkOutput("lit_b2b_en", sr_en, (c >= 1 && c <= 3) || c == 6 || c == 7);
            checkOutput("lit_b2b_done", done, c == 5 || c == 9);
            if (c <= 3) checkOutput("lit_b2b_d_first", sr_d, 8'h3C);
            if (c == 6 || c == 7) begin
                checkOutput("lit_b2b_d_second", sr_d, 8'hC3);
                checkOutput("lit_b2b_dir_second", sr_dir, 2'b11);
            end
        end

        // Reset in the middle of a command: enables drop, no done follows.
        cmd_valid = 1'b1;
        cmd_dir   = 2'b01;
        cmd_count = 4'd5;
        cmd_data  = 8'h77;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (c <= 2) checkOutput("lit_mrst_en_before", sr_en, 1'b1);
            if (c == 2) rstn = 1'b0;
            if (c == 3) begin
                checkOutput("lit_mrst_busy", busy, 1'b0);
                checkOutput("lit_mrst_ready", cmd_ready, 1'b0);
                rstn = 1'b1;
            end
            if (c >= 3) begin
                checkOutput("lit_mrst_en_after", sr_en, 1'b0);
                checkOutput("lit_mrst_no_done", done, 1'b0);
            end
        end

`ifdef SHIFT_SEQ_CAPTURE_EN
        applyStimulus(2'b11, 4'd1, 8'h01, 0, 32'h0000_0002, 3, 1'b0);
        applyStimulus(2'b01, 4'd3, 8'h01, 0, 32'h0000_000E, 5, 1'b0);
        checkOutput("lit_capture_result", result, 8'h08);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
